// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// A grant is held for a whole message and force-released on a byte cap or stall timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]     i_req_last,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic                   o_busy,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_dbg_state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last_owner;
    logic [BW-1:0]   r_burst_cnt;
    logic [TW-1:0]   r_to_cnt;

    logic            w_locked;
    logic            w_own_valid;
    logic            w_own_last;
    logic [7:0]      w_own_data;
    logic            w_xfer;
    logic            w_burst_hit;
    logic            w_to_hit;
    logic            w_release;
    logic            w_found;
    logic [IW-1:0]   w_next_owner;
    int              w_idx;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        w_found      = 1'b0;
        w_next_owner = r_last_owner;
        w_idx        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = (int'(r_last_owner) + i) % NUM_REQ;
            if (!w_found && i_req_valid[w_idx[IW-1:0]]) begin
                w_found      = 1'b1;
                w_next_owner = w_idx[IW-1:0];
            end
        end
    end

    assign w_locked    = (r_state == LOCKED);
    assign w_own_valid = i_req_valid[r_owner];
    assign w_own_last  = i_req_last[r_owner];
    assign w_own_data  = i_req_data[{r_owner, 3'b000} +: 8];

    // Handshake: a byte moves when the owner's valid and the transmitter's ready are both
    // high on a clock edge; the owner's ready mirrors i_tx_ready, and nothing moves in IDLE.
    assign w_xfer      = w_locked && w_own_valid && i_tx_ready;
    assign w_burst_hit = (MAX_BURST != 0) && w_xfer && (r_burst_cnt == BURST_LAST);
    assign w_to_hit    = (TIMEOUT != 0) && w_locked && !w_own_valid && (r_to_cnt == TO_LAST);
    assign w_release   = (w_xfer && w_own_last) || w_burst_hit || w_to_hit;

    always_comb begin
        o_grant     = '0;
        o_req_ready = '0;
        if (w_locked) begin
            o_grant[r_owner]     = 1'b1;
            o_req_ready[r_owner] = i_tx_ready;
        end
        o_tx_valid = w_locked && w_own_valid;
        o_tx_data  = o_tx_valid ? w_own_data : 8'h00;
    end

    assign o_busy      = w_locked;
    assign o_dbg_state = r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_owner <= IW'(NUM_REQ - 1);
            r_burst_cnt  <= '0;
            r_to_cnt     <= '0;
        end else if (r_state == IDLE) begin
            r_burst_cnt <= '0;
            r_to_cnt    <= '0;
            if (w_found) begin
                r_owner <= w_next_owner;
                r_state <= LOCKED;
            end
        end else begin
            if (w_release) begin
                r_state      <= IDLE;
                r_last_owner <= r_owner;
                r_burst_cnt  <= '0;
                r_to_cnt     <= '0;
            end else if (w_xfer) begin
                if (MAX_BURST != 0) r_burst_cnt <= r_burst_cnt + 1'b1;
                r_to_cnt <= '0;
            end else if (!w_own_valid && (TIMEOUT != 0)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    a_grant_onehot: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_grant));
    a_ready_in_grant: assert property (@(posedge i_clk) disable iff (i_rst) (o_req_ready & ~o_grant) == '0);
    a_valid_busy: assert property (@(posedge i_clk) disable iff (i_rst) o_tx_valid |-> o_busy);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester models and a paced transmitter model,
// with byte and grant scoreboards checked by an independent monitor.
module tb_uart_tx_arbiter;

    localparam int NR     = 4;
    localparam int TX_GAP = 2;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [NR-1:0]   i_req_valid;
    logic [8*NR-1:0] i_req_data;
    logic [NR-1:0]   i_req_last;
    logic [NR-1:0]   o_req_ready;
    logic [NR-1:0]   o_grant;
    logic            o_busy;
    logic [7:0]      o_tx_data;
    logic            o_tx_valid;
    logic            i_tx_ready;
    logic            o_dbg_state;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
        .i_req_last(i_req_last), .o_req_ready(o_req_ready), .o_grant(o_grant), .o_busy(o_busy),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_dbg_state(o_dbg_state)
    );

    typedef struct {
        logic [NR-1:0] g;
        int            gap;
        int            fall;
    } gexp_t;

    logic [8:0]  req_q [NR][$];
    logic [11:0] exp_q[$];
    gexp_t       exp_g_q[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    int   last_xfer_cyc = 0;
    int   cur_fall = -1;
    int   tx_busy = 0;
    logic xfer_seen = 1'b0;
    logic [NR-1:0] prev_grant = '0;

    // Clock / reset-independent cycle counter
    initial forever #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic req_byte(input int k, input logic [7:0] d, input logic last);
        req_q[k].push_back({last, d});
    endtask

    task automatic exp_byte(input int k, input logic [7:0] d);
        logic [NR-1:0] g;
        g = '0;
        g[k] = 1'b1;
        exp_q.push_back({g, d});
    endtask

    task automatic exp_grant(input int k, input int gap, input int fall);
        gexp_t ge;
        ge.g = '0;
        ge.g[k] = 1'b1;
        ge.gap = gap;
        ge.fall = fall;
        exp_g_q.push_back(ge);
    endtask

    // Requester and transmitter models: inputs change just after each rising edge.
    initial begin
        i_req_valid = '0;
        i_req_last  = '0;
        i_req_data  = '0;
        i_tx_ready  = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst) tx_busy = 0;
            else if (xfer_seen) tx_busy = TX_GAP;
            xfer_seen = 1'b0;
            i_tx_ready = (tx_busy == 0);
            if (tx_busy > 0) tx_busy--;
            for (int k = 0; k < NR; k++) begin
                if (req_q[k].size() != 0) begin
                    i_req_valid[k]      = 1'b1;
                    i_req_last[k]       = req_q[k][0][8];
                    i_req_data[8*k +: 8] = req_q[k][0][7:0];
                end else begin
                    i_req_valid[k]      = 1'b0;
                    i_req_last[k]       = 1'b0;
                    i_req_data[8*k +: 8] = 8'hEE;
                end
            end
        end
    end

    // Monitor: compares accepted bytes and grant episodes against the expected queues.
    initial begin
        gexp_t       ge;
        logic [11:0] e;
        logic [8:0]  dropped;
        forever begin
            @(negedge i_clk);
            if (o_tx_valid && i_tx_ready) begin
                xfer_seen = 1'b1;
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_byte_unexpected: got 0x%0h expected none (cycle %0d)",
                             {o_grant, o_tx_data}, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {20'h0, o_grant, o_tx_data}, {20'h0, e});
                end
                for (int k = 0; k < NR; k++)
                    if (o_req_ready[k] && i_req_valid[k] && req_q[k].size() != 0)
                        dropped = req_q[k].pop_front();
            end
            if (o_busy && !o_tx_valid) check("tx_data_zero", {24'h0, o_tx_data}, 32'h0);
            if (prev_grant == '0 && o_grant != '0) begin
                if (exp_g_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_unexpected: got 0x%0h expected none (cycle %0d)", o_grant, cyc);
                end else begin
                    ge = exp_g_q.pop_front();
                    check("grant", {28'h0, o_grant}, {28'h0, ge.g});
                    if (ge.gap >= 0) check("idle_gap", cyc - fall_cyc, ge.gap);
                    cur_fall = ge.fall;
                end
            end else if (prev_grant != '0 && o_grant == '0) begin
                fall_cyc = cyc;
                if (cur_fall >= 0) check("release_delay", cyc - last_xfer_cyc, cur_fall);
            end else if (prev_grant != '0 && o_grant != prev_grant) begin
                checks++;
                failures++;
                $display("FAIL grant_switch: got 0x%0h expected 0x%0h or 0 (cycle %0d)",
                         o_grant, prev_grant, cyc);
            end
            prev_grant = o_grant;
        end
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        for (int k = 0; k < NR; k++) req_q[k].delete();
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_g_q.size() != 0 || o_busy) && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
        check(name, {31'h0, (n < 500)}, 32'h1);
    endtask

    initial begin
        int n;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_grant", {28'h0, o_grant}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        check("rst_req_ready", {28'h0, o_req_ready}, 32'h0);
        check("rst_tx_data", {24'h0, o_tx_data}, 32'h0);
        check("rst_state", {31'h0, o_dbg_state}, 32'h0);
        i_rst = 1'b0;

        // Single 3-byte message from requester 0
        do_reset();
        req_byte(0, 8'h41, 1'b0); req_byte(0, 8'h42, 1'b0); req_byte(0, 8'h43, 1'b1);
        exp_byte(0, 8'h41); exp_byte(0, 8'h42); exp_byte(0, 8'h43);
        exp_grant(0, -1, 1);
        @(negedge i_clk);
        check("grant_before_latency", {28'h0, o_grant}, 32'h0);
        @(negedge i_clk);
        check("grant_after_latency", {28'h0, o_grant}, 32'h1);
        check("state_locked", {31'h0, o_dbg_state}, 32'h1);
        wait_drain("t1_drain");

        // Two simultaneous messages: no interleave, one idle cycle between
        do_reset();
        req_byte(0, 8'h10, 1'b0); req_byte(0, 8'h11, 1'b1);
        req_byte(2, 8'h20, 1'b0); req_byte(2, 8'h21, 1'b1);
        exp_byte(0, 8'h10); exp_byte(0, 8'h11); exp_byte(2, 8'h20); exp_byte(2, 8'h21);
        exp_grant(0, -1, 1); exp_grant(2, 1, 1);
        wait_drain("t2_drain");

        // All requesters busy with 1-byte messages: strict rotation
        do_reset();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < NR; k++) begin
                req_byte(k, 8'(k * 16 + m), 1'b1);
                exp_byte(k, 8'(k * 16 + m));
                exp_grant(k, (m == 0 && k == 0) ? -1 : 1, 1);
            end
        wait_drain("t3_drain");

        // Burst cap of 4: requester 1 is cut off, requester 3 served, then 1 resumes
        do_reset();
        for (int i = 0; i < 6; i++) req_byte(1, 8'hA0 + 8'(i), (i == 5));
        req_byte(3, 8'hB0, 1'b0); req_byte(3, 8'hB1, 1'b1);
        for (int i = 0; i < 4; i++) exp_byte(1, 8'hA0 + 8'(i));
        exp_byte(3, 8'hB0); exp_byte(3, 8'hB1);
        exp_byte(1, 8'hA4); exp_byte(1, 8'hA5);
        exp_grant(1, -1, 1); exp_grant(3, 1, 1); exp_grant(1, 1, 1);
        wait_drain("t4_drain");

        // Stall timeout of 8: grant clears 8 cycles after valid drops
        do_reset();
        req_byte(0, 8'hC0, 1'b0);
        req_byte(1, 8'hD0, 1'b1);
        exp_byte(0, 8'hC0); exp_byte(1, 8'hD0);
        exp_grant(0, -1, 9); exp_grant(1, 1, 1);
        wait_drain("t5_drain");

        // Reset in the middle of a message
        do_reset();
        req_byte(2, 8'hE0, 1'b0); req_byte(2, 8'hE1, 1'b0); req_byte(2, 8'hE2, 1'b1);
        exp_byte(2, 8'hE0);
        exp_grant(2, -1, -1);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("t6_first_byte", {31'h0, (n < 100)}, 32'h1);
        @(negedge i_clk);
        i_rst = 1'b1;
        for (int k = 0; k < NR; k++) req_q[k].delete();
        @(negedge i_clk);
        check("t6_grant_cleared", {28'h0, o_grant}, 32'h0);
        check("t6_tx_valid_cleared", {31'h0, o_tx_valid}, 32'h0);
        check("t6_busy_cleared", {31'h0, o_busy}, 32'h0);
        i_rst = 1'b0;
        req_byte(0, 8'hF0, 1'b1);
        req_byte(3, 8'hF3, 1'b1);
        exp_byte(0, 8'hF0); exp_byte(3, 8'hF3);
        exp_grant(0, -1, 1); exp_grant(3, 1, 1);
        wait_drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
